// File: rtl/mulfold_c_gen_pkg.sv
// rtl/mulfold_c_gen_pkg.sv - shared constants and FSM encoding for the mod-(2^13-1) multiply/fold producer
`ifndef Datawidth
`define Datawidth 16
`endif

package mulfold_c_gen_pkg;

    localparam int W_DEFAULT     = 13;
    localparam int CNT_W_DEFAULT = 4;
    localparam int MOD           = (1 << W_DEFAULT) - 1;
    localparam int DW            = `Datawidth;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        FOLD = 2'd2
    } state_t;

endpackage

// File: rtl/mulfold_c_gen.sv
// rtl/mulfold_c_gen.sv - shift-add a*b with one high+low fold onto c/en; optional MULFOLD_EARLY_EXIT_EN
module mulfold_c_gen
    import mulfold_c_gen_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic                  busy,
    output logic [`Datawidth-1:0] c,
    output logic                  en
);

    state_t           state;
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   a_sh;
    logic [W-1:0]     b_sh;
    logic [CNT_W-1:0] cnt;

    logic [W:0]       fold_sum;
    logic [W-1:0]     b_next;
    logic             last_step;

    // Single fold only; the downstream stage absorbs the carry in bit W.
    assign fold_sum = {1'b0, acc[2*W-1:W]} + {1'b0, acc[W-1:0]};
    assign b_next   = b_sh >> 1;

`ifdef MULFOLD_EARLY_EXIT_EN
    assign last_step = (cnt == CNT_W'(W - 1)) || (b_next == '0);
`else
    assign last_step = (cnt == CNT_W'(W - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            en    <= 1'b0;
            c     <= '0;
            acc   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
        end else begin
            en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= {{W{1'b0}}, a};
                        b_sh  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (b_sh[0]) begin
                        acc <= acc + a_sh;
                    end
                    a_sh <= a_sh << 1;
                    b_sh <= b_next;
                    cnt  <= cnt + 1'b1;
                    if (last_step) begin
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    c     <= DW'(fold_sum);
                    en    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mulfold_c_gen.sv
// tb/tb_mulfold_c_gen.sv - directed and random scoreboard bench for mulfold_c_gen
`ifndef Datawidth
`define Datawidth 16
`endif

module tb_mulfold_c_gen;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [12:0]           a;
    logic [12:0]           b;
    logic                  busy;
    logic [`Datawidth-1:0] c;
    logic                  en;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    mulfold_c_gen dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .c     (c),
        .en    (en)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [12:0] x, input logic [12:0] y);
        logic [25:0] p;
        p = 26'(x) * 26'(y);
        return 32'(p[25:13]) + 32'(p[12:0]);
    endfunction

    function automatic int exp_lat(input logic [12:0] y);
`ifdef MULFOLD_EARLY_EXIT_EN
        int m;
        m = 0;
        for (int i = 0; i < 13; i++) if (y[i]) m = i;
        return m + 2;
`else
        return 14;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Called #1 after a rising edge; leaves the bench #1 after the edge following en.
    task automatic run_op(input logic [12:0] x, input logic [12:0] y, input string tag);
        int          lat;
        logic [31:0] e;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(model(x, y));
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, "_busy_hi"}, 32'(busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (en) begin
                lat = k;
                break;
            end
        end
        e = exp_q.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(y)));
        chk({tag, "_c"}, 32'(c), e);
        chk({tag, "_busy_lo"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1 chk({tag, "_en_one_cycle"}, 32'(en), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        int          t1;
        int          t2;
        logic [12:0] ra;
        logic [12:0] rb;

        reset = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_en", 32'(en), 32'd0);
        chk("reset_c", 32'(c), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_op(13'd3, 13'd5, "a3_b5");
        run_op(13'd8191, 13'd8191, "max_max");
        run_op(13'd4096, 13'd4, "a4096_b4");
        run_op(13'd0, 13'd1234, "a0");
        run_op(13'd1234, 13'd1, "b1");
        run_op(13'd777, 13'h1000, "b_msb");
        run_op(13'd555, 13'd0, "b0");

        // Re-pulse start mid-MUL and on the FOLD edge; only one result may appear.
        a     = 13'd100;
        b     = 13'h1ABC;
        start = 1'b1;
        exp_q.push_back(model(13'd100, 13'h1ABC));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("repulse_en_at_fold", 32'(en), 32'd1);
        chk("repulse_c", 32'(c), exp_q.pop_front());
        pulses = en ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (en) pulses++;
        end
        chk("repulse_pulses", 32'(pulses), 32'd1);
        chk("repulse_idle", 32'(busy), 32'd0);

        // start held high: back-to-back results every W+2 cycles.
        a     = 13'd77;
        b     = 13'h1F00;
        start = 1'b1;
        t1    = -1;
        t2    = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (en) begin
                chk("held_c", 32'(c), model(13'd77, 13'h1F00));
                if (t1 < 0) t1 = k;
                else begin
                    t2 = k;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("held_period", 32'(t2 - t1), 32'd15);
        for (int k = 0; k < 20 && busy; k++) @(posedge clk);
        #1 chk("held_drained", 32'(busy), 32'd0);

        // Asynchronous reset at T0+7 aborts the op with no en.
        a     = 13'd5;
        b     = 13'h1234;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_en", 32'(en), 32'd0);
        chk("abort_c", 32'(c), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (en) pulses++;
        end
        chk("abort_no_en", 32'(pulses), 32'd0);
        run_op(13'd9, 13'd10, "after_reset");

        for (int i = 0; i < 12; i++) begin
            ra = 13'($urandom_range(0, 8191));
            rb = 13'($urandom_range(0, 8191));
            run_op(ra, rb, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
